// File: rtl/hpc_pkg.sv
// Shared encodings for the HPC counter-bank access controller.
package hpc_pkg;

  // Command opcodes carried on req_op
  localparam logic [1:0] HPC_OP_READ      = 2'b00;
  localparam logic [1:0] HPC_OP_CLEAR     = 2'b01;
  localparam logic [1:0] HPC_OP_CLEAR_ALL = 2'b10;
  localparam logic [1:0] HPC_OP_RSVD      = 2'b11;

  // Counter bank layout
  localparam int HPC_NUM_CNT = 6;
  localparam int HPC_IDX_R   = 0;
  localparam int HPC_IDX_I   = 1;
  localparam int HPC_IDX_S   = 2;
  localparam int HPC_IDX_B   = 3;
  localparam int HPC_IDX_U   = 4;
  localparam int HPC_IDX_J   = 5;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SWEEP = 3'd3,
    ST_RESP  = 3'd4
  } hpc_state_e;

  // A command is rejected for a reserved opcode or an index past the bank.
  // The index check applies to every opcode, CLEAR_ALL included.
  function automatic logic hpc_cmd_err(input logic [1:0]  op,
                                       input int unsigned idx,
                                       input int unsigned num_cnt);
    return (op == HPC_OP_RSVD) || (idx >= num_cnt);
  endfunction

endpackage

// File: rtl/hpc_rr_arbiter.sv
// Round-robin arbiter: grants the first valid requester at or after the
// pointer; the pointer moves past the winner whenever a grant is taken.
module hpc_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_i,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_id,
  output logic               grant_any
);

  logic [PTR_W-1:0] ptr;

  // Two passes: requesters at/after the pointer first, then the wrapped ones
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    if (en) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_any && req_valid[i] && (i >= int'(ptr))) begin
          grant_any = 1'b1;
          grant_id  = PTR_W'(i);
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_any && req_valid[i]) begin
          grant_any = 1'b1;
          grant_id  = PTR_W'(i);
        end
      end
      if (grant_any) grant = NUM_REQ'(1) << grant_id;
    end
  end

  // Pointer advances to the requester after the winner, wrapping at NUM_REQ-1
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      ptr <= '0;
    end else if (grant_any) begin
      ptr <= (grant_id == PTR_W'(NUM_REQ - 1)) ? '0 : grant_id + PTR_W'(1);
    end
  end

endmodule

// File: rtl/hpc_access_ctrl.sv
// Access controller for the shared HPC counter bank: arbitrates read/clear/
// clear-all commands, drives the single bank port and returns responses.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no command in flight; arbiter may grant
// ST_ISSUE | one-cycle bank strobe (read or single clear)
// ST_WAIT  | RD_LAT cycles for bank read data, captured on the last one
// ST_SWEEP | clear-all: freeze high, clear idx 0..NUM_CNT-1
// ST_RESP  | response held to granted requester until its rsp_ready
module hpc_access_ctrl
  import hpc_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int NUM_CNT = HPC_NUM_CNT,
  parameter int IDX_W   = 3,
  parameter int RD_LAT  = 1
) (
  input  logic                     clk,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [2*NUM_REQ-1:0]     req_op,
  input  logic [IDX_W*NUM_REQ-1:0] req_idx,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [31:0]              rsp_data,
  output logic                     rsp_err,
  output logic                     bank_rd_en,
  output logic                     bank_clr,
  output logic [IDX_W-1:0]         bank_idx,
  input  logic [31:0]              bank_rd_data,
  output logic                     hpc_freeze,
  output logic                     busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int LAT_W = $clog2(RD_LAT + 1);

  hpc_state_e state, state_nxt;

  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_id;
  logic               grant_any;
  logic               arb_en;
  logic [1:0]         sel_op;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_err;

  logic [1:0]         op_q;
  logic [IDX_W-1:0]   idx_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic               err_q;
  logic [31:0]        data_q;
  logic [LAT_W-1:0]   lat_cnt;
  logic [IDX_W-1:0]   sweep_idx;
  logic               lat_last;
  logic               sweep_last;

  // Grants only from IDLE, and never while reset is held
  assign arb_en = (state == ST_IDLE) && rst_i;

  hpc_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .clk       (clk),
    .rst_i     (rst_i),
    .en        (arb_en),
    .req_valid (req_valid),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_any (grant_any)
  );

  assign req_ready  = grant;
  assign sel_op     = req_op[{grant_id, 1'b0} +: 2];
  assign sel_idx    = req_idx[grant_id*IDX_W +: IDX_W];
  assign sel_err    = hpc_cmd_err(sel_op, 32'(sel_idx), NUM_CNT);
  assign lat_last   = (lat_cnt == LAT_W'(1));
  assign sweep_last = (sweep_idx == IDX_W'(NUM_CNT - 1));
  assign busy       = (state != ST_IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Command latches, read-latency down-counter and sweep index
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      op_q      <= HPC_OP_READ;
      idx_q     <= '0;
      gnt_q     <= '0;
      err_q     <= 1'b0;
      data_q    <= '0;
      lat_cnt   <= '0;
      sweep_idx <= '0;
    end else begin
      if (grant_any) begin
        op_q      <= sel_op;
        idx_q     <= sel_idx;
        gnt_q     <= grant;
        err_q     <= sel_err;
        data_q    <= '0;
        sweep_idx <= '0;
      end
      if (state == ST_ISSUE) lat_cnt <= LAT_W'(RD_LAT);
      if (state == ST_WAIT) begin
        if (lat_last) data_q  <= bank_rd_data;
        else          lat_cnt <= lat_cnt - LAT_W'(1);
      end
      if ((state == ST_SWEEP) && !sweep_last) sweep_idx <= sweep_idx + IDX_W'(1);
    end
  end

  // Next-state and bank/response outputs
  always_comb begin
    state_nxt  = state;
    bank_rd_en = 1'b0;
    bank_clr   = 1'b0;
    bank_idx   = '0;
    hpc_freeze = 1'b0;
    rsp_valid  = '0;
    rsp_data   = '0;
    rsp_err    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_any) begin
          if (sel_err)                         state_nxt = ST_RESP;
          else if (sel_op == HPC_OP_CLEAR_ALL) state_nxt = ST_SWEEP;
          else                                 state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        bank_idx = idx_q;
        if (op_q == HPC_OP_READ) begin
          bank_rd_en = 1'b1;
          state_nxt  = ST_WAIT;
        end else begin
          bank_clr  = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_WAIT: begin
        if (lat_last) state_nxt = ST_RESP;
      end
      ST_SWEEP: begin
        hpc_freeze = 1'b1;
        bank_clr   = 1'b1;
        bank_idx   = sweep_idx;
        if (sweep_last) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = gnt_q;
        rsp_data  = data_q;
        rsp_err   = err_q;
        if ((rsp_ready & gnt_q) != '0) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_hpc_access_ctrl.sv
// Scoreboard bench for hpc_access_ctrl: directed commands push expected
// responses; a monitor pops and compares whenever rsp_valid is presented.
module tb_hpc_access_ctrl;
  import hpc_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int NUM_CNT = 6;
  localparam int IDX_W   = 3;
  localparam int RD_LAT  = 1;

  logic                     clk = 1'b0;
  logic                     rst_i;
  logic [NUM_REQ-1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
  logic [2*NUM_REQ-1:0]     req_op;
  logic [IDX_W*NUM_REQ-1:0] req_idx;
  logic [31:0]              rsp_data;
  logic [31:0]              bank_rd_data = '0;
  logic                     rsp_err, bank_rd_en, bank_clr, hpc_freeze, busy;
  logic [IDX_W-1:0]         bank_idx;

  typedef struct {
    logic [NUM_REQ-1:0] gnt;
    logic [31:0]        data;
    logic               err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem [8];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  hpc_access_ctrl #(
    .NUM_REQ (NUM_REQ),
    .NUM_CNT (NUM_CNT),
    .IDX_W   (IDX_W),
    .RD_LAT  (RD_LAT)
  ) dut (
    .clk          (clk),
    .rst_i        (rst_i),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_idx      (req_idx),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .bank_rd_en   (bank_rd_en),
    .bank_clr     (bank_clr),
    .bank_idx     (bank_idx),
    .bank_rd_data (bank_rd_data),
    .hpc_freeze   (hpc_freeze),
    .busy         (busy)
  );

  // Bank model with one cycle of read latency
  always @(posedge clk) if (bank_rd_en) bank_rd_data <= mem[bank_idx];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int r, input logic v, input logic [1:0] op, input logic [IDX_W-1:0] idx);
    req_valid[r]              = v;
    req_op[r*2 +: 2]          = op;
    req_idx[r*IDX_W +: IDX_W] = idx;
  endtask

  task automatic push(input logic [NUM_REQ-1:0] g, input logic [31:0] d, input logic e);
    exp_t x;
    x.gnt  = g;
    x.data = d;
    x.err  = e;
    exp_q.push_back(x);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy !== 1'b0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk(name, busy, 0);
  endtask

  // Response monitor and per-cycle bank invariants
  initial begin
    bit   in_resp;
    bit   have_cur;
    exp_t cur;
    in_resp  = 0;
    have_cur = 0;
    forever begin
      @(negedge clk);
      chk("rd_clr_exclusive", bank_rd_en & bank_clr, 0);
      chk("freeze_only_with_clr", hpc_freeze & ~bank_clr, 0);
      if (rsp_valid != '0) begin
        if (!in_resp) begin
          if (exp_q.size() == 0) begin
            have_cur = 0;
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_rsp: rsp_valid=%b, required no response", rsp_valid);
          end else begin
            cur      = exp_q.pop_front();
            have_cur = 1;
          end
        end
        if (have_cur) begin
          chk("rsp_valid", rsp_valid, cur.gnt);
          chk("rsp_data", rsp_data, cur.data);
          chk("rsp_err", rsp_err, cur.err);
        end
        in_resp = ((rsp_valid & rsp_ready) == '0);
      end else begin
        in_resp = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int k;
    mem = '{32'h11, 32'h22, 32'hA5, 32'h44, 32'h55, 32'h66, 32'hDEAD, 32'hBEEF};
    rst_i = 1'b0;
    req_valid = '0;
    req_op = '0;
    req_idx = '0;
    rsp_ready = '1;

    // Reset state
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_freeze", hpc_freeze, 0);
    chk("rst_clr", bank_clr, 0);
    chk("rst_rd_en", bank_rd_en, 0);
    #2 rst_i = 1'b1;

    // 1: READ idx2, exact latency
    @(posedge clk); #1;
    drive(0, 1'b1, HPC_OP_READ, 3'(HPC_IDX_S));
    @(negedge clk);
    chk("t1_grant", req_ready, 2'b01);
    push(2'b01, 32'hA5, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, HPC_OP_READ, 3'd0);
    @(negedge clk);
    chk("t1_rd_en", bank_rd_en, 1);
    chk("t1_bank_idx", bank_idx, 2);
    chk("t1_no_clr", bank_clr, 0);
    @(negedge clk);
    chk("t1_not_yet_valid", rsp_valid, 0);
    @(negedge clk);
    chk("t1_valid_at_t3", rsp_valid, 2'b01);
    wait_idle("t1_idle");

    // 2: both requesters always valid, from a fresh pointer
    @(negedge clk); #1 rst_i = 1'b0;
    @(negedge clk);
    chk("t2_rst_busy", busy, 0);
    #1 rst_i = 1'b1;
    @(posedge clk); #1;
    drive(0, 1'b1, HPC_OP_READ, 3'd0);
    drive(1, 1'b1, HPC_OP_READ, 3'd1);
    g = 0;
    k = 0;
    while (g < 4 && k < 60) begin
      @(negedge clk);
      k++;
      if (req_ready != '0) begin
        chk("t2_grant_order", req_ready, (g % 2 == 0) ? 2'b01 : 2'b10);
        chk("t2_grant_in_idle", busy, 0);
        push((g % 2 == 0) ? 2'b01 : 2'b10, (g % 2 == 0) ? mem[0] : mem[1], 1'b0);
        g++;
      end
    end
    chk("t2_grant_count", g, 4);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle("t2_idle");

    // 3: CLEAR_ALL sweep from requester 1
    @(posedge clk); #1;
    drive(1, 1'b1, HPC_OP_CLEAR_ALL, 3'd0);
    @(negedge clk);
    chk("t3_grant", req_ready, 2'b10);
    push(2'b10, 32'h0, 1'b0);
    @(posedge clk); #1;
    drive(1, 1'b0, HPC_OP_READ, 3'd0);
    for (int i = 0; i < NUM_CNT; i++) begin
      @(negedge clk);
      chk("t3_freeze", hpc_freeze, 1);
      chk("t3_clr", bank_clr, 1);
      chk("t3_sweep_idx", bank_idx, i);
    end
    @(negedge clk);
    chk("t3_freeze_drop", hpc_freeze, 0);
    chk("t3_clr_drop", bank_clr, 0);
    chk("t3_rsp_valid", rsp_valid, 2'b10);
    wait_idle("t3_idle");

    // 4: READ of an out-of-range index
    @(posedge clk); #1;
    drive(0, 1'b1, HPC_OP_READ, 3'd7);
    @(negedge clk);
    chk("t4_grant", req_ready, 2'b01);
    push(2'b01, 32'h0, 1'b1);
    @(posedge clk); #1;
    drive(0, 1'b0, HPC_OP_READ, 3'd0);
    @(negedge clk);
    chk("t4_no_rd_en", bank_rd_en, 0);
    chk("t4_no_clr", bank_clr, 0);
    chk("t4_direct_rsp", rsp_valid, 2'b01);
    wait_idle("t4_idle");

    // 5: response back-pressure; other requester's ready ignored
    @(posedge clk); #1;
    rsp_ready = 2'b10;
    drive(0, 1'b1, HPC_OP_READ, 3'(HPC_IDX_U));
    @(negedge clk);
    chk("t5_grant", req_ready, 2'b01);
    push(2'b01, 32'h55, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, HPC_OP_READ, 3'd0);
    drive(1, 1'b1, HPC_OP_READ, 3'(HPC_IDX_J));
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_hold_valid", rsp_valid, 2'b01);
      chk("t5_no_grant", req_ready, 0);
      chk("t5_busy", busy, 1);
    end
    @(posedge clk); #1;
    rsp_ready = 2'b11;
    @(negedge clk);
    chk("t5_valid_with_ready", rsp_valid, 2'b01);
    @(negedge clk);
    chk("t5_idle_after_ready", busy, 0);
    chk("t5_next_grant", req_ready, 2'b10);
    push(2'b10, 32'h66, 1'b0);
    @(posedge clk); #1;
    drive(1, 1'b0, HPC_OP_READ, 3'd0);
    wait_idle("t5_idle");

    // 6: reset in the middle of a sweep
    @(posedge clk); #1;
    drive(0, 1'b1, HPC_OP_CLEAR_ALL, 3'd0);
    @(negedge clk);
    chk("t6_grant", req_ready, 2'b01);
    @(posedge clk); #1;
    drive(0, 1'b0, HPC_OP_READ, 3'd0);
    repeat (4) @(negedge clk);
    chk("t6_sweep_idx3", bank_idx, 3);
    chk("t6_freeze_before", hpc_freeze, 1);
    #1 rst_i = 1'b0;
    #1;
    chk("t6_freeze_abort", hpc_freeze, 0);
    chk("t6_clr_abort", bank_clr, 0);
    chk("t6_busy_abort", busy, 0);
    chk("t6_no_rsp", rsp_valid, 0);
    #10 rst_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_no_resume_clr", bank_clr, 0);
      chk("t6_no_resume_freeze", hpc_freeze, 0);
      chk("t6_idle", busy, 0);
    end
    @(posedge clk); #1;
    drive(0, 1'b1, HPC_OP_READ, 3'(HPC_IDX_B));
    @(negedge clk);
    chk("t6_fresh_grant", req_ready, 2'b01);
    push(2'b01, 32'h44, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, HPC_OP_READ, 3'd0);
    wait_idle("t6_fresh_idle");

    repeat (3) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
